depth_test_unit: RTL and testbench

DEPTH_TEST_UNIT -- requirements
Module: depth_test_unit

---
 rtl/depth_test_unit_if.sv | 35 +++
 rtl/depth_test_unit.sv | 192 +++++++++++++++++++
 tb/tb_depth_test_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/depth_test_unit_if.sv
// Bus bundle for depth_test_unit: fragment input handshake, result output handshake and flush control.
interface depth_test_unit_if #(
    parameter int unsigned X_W     = 11,
    parameter int unsigned Y_W     = 10,
    parameter int unsigned Z_WIDTH = 16,
    parameter int unsigned TAG_W   = 8
);
    logic               frag_valid_i;
    logic               frag_ready_o;
    logic [X_W-1:0]     frag_x_i;
    logic [Y_W-1:0]     frag_y_i;
    logic [Z_WIDTH-1:0] frag_z_i;
    logic [TAG_W-1:0]   frag_tag_i;
    logic [2:0]         cmp_mode_i;
    logic               zwrite_i;
    logic               res_valid_o;
    logic               res_ready_i;
    logic               res_pass_o;
    logic [TAG_W-1:0]   res_tag_o;
    logic               flush_i;
    logic               flush_busy_o;
    logic               flush_done_o;

    modport slave (
        input  frag_valid_i, frag_x_i, frag_y_i, frag_z_i, frag_tag_i, cmp_mode_i, zwrite_i,
        input  res_ready_i, flush_i,
        output frag_ready_o, res_valid_o, res_pass_o, res_tag_o, flush_busy_o, flush_done_o
    );

    modport master (
        output frag_valid_i, frag_x_i, frag_y_i, frag_z_i, frag_tag_i, cmp_mode_i, zwrite_i,
        output res_ready_i, flush_i,
        input  frag_ready_o, res_valid_o, res_pass_o, res_tag_o, flush_busy_o, flush_done_o
    );
endinterface

// File: rtl/depth_test_unit.sv
// Depth test unit: 2-cycle z-buffer compare/update pipeline with a flush sweep that invalidates storage.
// Optional macro DEPTH_FWD_EN forwards the stage-2 write to a back-to-back same-address fragment instead of stalling.
module depth_test_unit #(
    parameter int unsigned Z_WIDTH = 16,
    parameter int unsigned X_RES   = 1280,
    parameter int unsigned Y_RES   = 720,
    parameter int unsigned TAG_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    depth_test_unit_if.slave bus
);
    localparam int unsigned X_W   = $clog2(X_RES);
    localparam int unsigned Y_W   = $clog2(Y_RES);
    localparam int unsigned DEPTH = X_RES * Y_RES;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [2:0] M_NEVER    = 3'd0;
    localparam logic [2:0] M_LESS     = 3'd1;
    localparam logic [2:0] M_EQUAL    = 3'd2;
    localparam logic [2:0] M_LEQUAL   = 3'd3;
    localparam logic [2:0] M_GREATER  = 3'd4;
    localparam logic [2:0] M_NOTEQUAL = 3'd5;
    localparam logic [2:0] M_GEQUAL   = 3'd6;
    localparam logic [2:0] M_ALWAYS   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               in_range;
        logic [AW-1:0]      addr;
        logic [Z_WIDTH-1:0] z;
        logic [TAG_W-1:0]   tag;
        logic [2:0]         mode;
        logic               zwrite;
    } stage_t;

    state_t             state_q, state_d;
    stage_t             in_c, s1_q, s2_q;
    logic [AW-1:0]      sweep_addr_q;
    logic               flush_done_q;
    logic               res_valid_q, res_pass_q;
    logic [TAG_W-1:0]   res_tag_q;
    logic [Z_WIDTH:0]   mem [DEPTH];
    logic [Z_WIDTH:0]   rd_q;
    logic               s2_fwd_q;
    logic [Z_WIDTH-1:0] s2_fwd_z_q;
    logic [X_W-1:0]     frag_x_c;
    logic [Y_W-1:0]     frag_y_c;
    logic [Z_WIDTH:0]   stored_c;
    logic               frozen_c, advance_c, hazard_c, ready_c, accept_c, pipe_empty_c;
    logic               pass_c, pipe_we_c, fwd_hit_c, busy_c, sweep_we_c, sweep_last_c;

    assign frag_x_c = bus.frag_x_i;
    assign frag_y_c = bus.frag_y_i;

    // Incoming fragment decode: range check and linear address
    always_comb begin
        in_c          = '0;
        in_c.in_range = (32'(frag_x_c) < X_RES) && (32'(frag_y_c) < Y_RES);
        in_c.addr     = in_c.in_range ? AW'(32'(frag_y_c) * X_RES + 32'(frag_x_c)) : '0;
        in_c.z        = bus.frag_z_i;
        in_c.tag      = bus.frag_tag_i;
        in_c.mode     = bus.cmp_mode_i;
        in_c.zwrite   = bus.zwrite_i;
    end

    assign frozen_c     = res_valid_q && !bus.res_ready_i;
    assign advance_c    = !frozen_c;
    assign pipe_empty_c = !s1_q.valid && !s2_q.valid && !res_valid_q;

`ifdef DEPTH_FWD_EN
    assign hazard_c  = 1'b0;
    assign fwd_hit_c = pipe_we_c && s1_q.valid && (s1_q.addr == s2_q.addr);
`else
    // Stage-1 read would miss the stage-2 write at the same edge; hold the newcomer one cycle
    assign hazard_c  = s1_q.valid && (s1_q.addr == in_c.addr);
    assign fwd_hit_c = 1'b0;
`endif

    assign ready_c  = (state_q == IDLE) && !bus.flush_i && advance_c && !hazard_c;
    assign accept_c = bus.frag_valid_i && ready_c;

    // Depth compare against stored entry (or the write that raced its read)
    always_comb begin
        stored_c = s2_fwd_q ? {1'b1, s2_fwd_z_q} : rd_q;
        pass_c   = 1'b0;
        if (s2_q.in_range) begin
            case (s2_q.mode)
                M_NEVER:    pass_c = 1'b0;
                M_LESS:     pass_c = !stored_c[Z_WIDTH] || (s2_q.z <  stored_c[Z_WIDTH-1:0]);
                M_EQUAL:    pass_c = !stored_c[Z_WIDTH] || (s2_q.z == stored_c[Z_WIDTH-1:0]);
                M_LEQUAL:   pass_c = !stored_c[Z_WIDTH] || (s2_q.z <= stored_c[Z_WIDTH-1:0]);
                M_GREATER:  pass_c = !stored_c[Z_WIDTH] || (s2_q.z >  stored_c[Z_WIDTH-1:0]);
                M_NOTEQUAL: pass_c = !stored_c[Z_WIDTH] || (s2_q.z != stored_c[Z_WIDTH-1:0]);
                M_GEQUAL:   pass_c = !stored_c[Z_WIDTH] || (s2_q.z >= stored_c[Z_WIDTH-1:0]);
                M_ALWAYS:   pass_c = 1'b1;
            endcase
        end
    end

    assign pipe_we_c = s2_q.valid && pass_c && s2_q.zwrite && advance_c && !rst_i;

    // Pipeline stages and result register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q.valid  <= 1'b0;
            s2_q.valid  <= 1'b0;
            s2_fwd_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_pass_q  <= 1'b0;
            res_tag_q   <= '0;
        end else if (advance_c) begin
            s1_q        <= in_c;
            s1_q.valid  <= accept_c;
            s2_q        <= s1_q;
            s2_fwd_q    <= fwd_hit_c;
            s2_fwd_z_q  <= s2_q.z;
            res_valid_q <= s2_q.valid;
            if (s2_q.valid) begin
                res_pass_q <= pass_c;
                res_tag_q  <= s2_q.tag;
            end
        end
    end

    // Storage: sweep clear has priority; pipeline cannot be writing during a sweep
    always_ff @(posedge clk_i) begin
        if (sweep_we_c) begin
            mem[sweep_addr_q] <= '0;
        end else if (pipe_we_c) begin
            mem[s2_q.addr] <= {1'b1, s2_q.z};
        end
        if (advance_c) begin
            rd_q <= mem[s1_q.addr];
        end
    end

    // Flush FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SWEEP;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.flush_i) state_d = DRAIN;
            DRAIN:   if (pipe_empty_c) state_d = SWEEP;
            SWEEP:   if (sweep_addr_q == LAST_ADDR) state_d = IDLE;
            default: state_d = SWEEP;
        endcase
    end

    // Flush FSM: outputs
    always_comb begin
        busy_c       = (state_q != IDLE);
        sweep_we_c   = (state_q == SWEEP) && !rst_i;
        sweep_last_c = (state_q == SWEEP) && (sweep_addr_q == LAST_ADDR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sweep_addr_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= sweep_last_c;
            if ((state_q == SWEEP) && !sweep_last_c) begin
                sweep_addr_q <= sweep_addr_q + AW'(1);
            end else begin
                sweep_addr_q <= '0;
            end
        end
    end

    assign bus.frag_ready_o = ready_c;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_pass_o   = res_pass_q;
    assign bus.res_tag_o    = res_tag_q;
    assign bus.flush_busy_o = busy_c;
    assign bus.flush_done_o = flush_done_q;
endmodule

// File: tb/tb_depth_test_unit.sv
// Bench for depth_test_unit: directed vectors, per-cycle scoreboard against a per-pixel depth buffer model.
// Define DEPTH_FWD_EN for both bench and design to cover the forwarding build.
module tb_depth_test_unit;
    localparam int XR = 12;
    localparam int YR = 8;
    localparam int DEPTH = XR * YR;
    localparam int ZW = 16;
    localparam int TW = 8;
`ifdef DEPTH_FWD_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif
    localparam int NEVER = 0, LESS = 1, EQUAL = 2, LEQUAL = 3;
    localparam int GREATER = 4, NOTEQUAL = 5, GEQUAL = 6, ALWAYS = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    depth_test_unit_if #(.X_W(4), .Y_W(3), .Z_WIDTH(ZW), .TAG_W(TW)) bus ();

    depth_test_unit #(.Z_WIDTH(ZW), .X_RES(XR), .Y_RES(YR), .TAG_W(TW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int tag_ctr = 1;
    int done_cnt = 0;
    int res_cnt = 0;

    typedef struct {
        int   tag;
        logic pass;
    } exp_t;

    exp_t exp_q[$];
    int   tag_log[$];
    logic got_pass [256];
    logic m_valid [XR][YR];
    int   m_z [XR][YR];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic ref_pass(input int mode, input logic v, input int fz, input int sz);
        if (mode == NEVER) return 1'b0;
        if (!v) return 1'b1;
        case (mode)
            LESS:     return fz <  sz;
            EQUAL:    return fz == sz;
            LEQUAL:   return fz <= sz;
            GREATER:  return fz >  sz;
            NOTEQUAL: return fz != sz;
            GEQUAL:   return fz >= sz;
            default:  return 1'b1;
        endcase
    endfunction

    // Scoreboard: model updated in acceptance order, results checked in emergence order
    always @(negedge clk) begin
        int   x, y, z, m;
        logic p;
        exp_t e;
        if (rst) begin
            foreach (m_valid[i, j]) m_valid[i][j] = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.flush_done_o) done_cnt++;
            if (bus.flush_i && !bus.flush_busy_o) begin
                foreach (m_valid[i, j]) m_valid[i][j] = 1'b0;
            end
            if (bus.frag_valid_i && bus.frag_ready_o) begin
                chk("accept_while_busy", bus.flush_busy_o, 0);
                x = int'(bus.frag_x_i);
                y = int'(bus.frag_y_i);
                z = int'(bus.frag_z_i);
                m = int'(bus.cmp_mode_i);
                p = 1'b0;
                if (x < XR && y < YR) begin
                    p = ref_pass(m, m_valid[x][y], z, m_z[x][y]);
                    if (p && bus.zwrite_i) begin
                        m_valid[x][y] = 1'b1;
                        m_z[x][y] = z;
                    end
                end
                e.tag = int'(bus.frag_tag_i);
                e.pass = p;
                exp_q.push_back(e);
            end
            if (bus.res_valid_o && bus.res_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_tag", bus.res_tag_o, e.tag);
                    chk("res_pass", bus.res_pass_o, e.pass);
                    got_pass[e.tag] = bus.res_pass_o;
                    tag_log.push_back(int'(bus.res_tag_o));
                    res_cnt++;
                end
            end
        end
    end

    task automatic send(input int x, input int y, input int z, input int m, input int zw,
                        output int tg, output int gaps);
        logic got;
        int   n;
        tg = tag_ctr;
        tag_ctr++;
        bus.frag_x_i = 4'(x);
        bus.frag_y_i = 3'(y);
        bus.frag_z_i = 16'(z);
        bus.cmp_mode_i = 3'(m);
        bus.zwrite_i = 1'(zw);
        bus.frag_tag_i = 8'(tg);
        bus.frag_valid_i = 1'b1;
        gaps = 0;
        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (bus.frag_ready_o) got = 1'b1;
            else gaps++;
            @(posedge clk);
            #2;
            n++;
        end
        bus.frag_valid_i = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.res_valid_o) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_done(output int n);
        logic got = 1'b0;
        n = 0;
        while (!got && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = bus.flush_done_o;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int       t [8];
        int       g, g2, gsum, n, d0, r0, busy, acc;
        int       tt_tag [8][3];
        logic [2:0] tt [8];
        logic     got;
        tt = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};

        bus.frag_valid_i = 1'b0;
        bus.frag_x_i = '0;
        bus.frag_y_i = '0;
        bus.frag_z_i = '0;
        bus.frag_tag_i = '0;
        bus.cmp_mode_i = '0;
        bus.zwrite_i = 1'b0;
        bus.res_ready_i = 1'b1;
        bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_res_valid", bus.res_valid_o, 0);
        chk("rst_flush_busy", bus.flush_busy_o, 1);
        chk("rst_frag_ready", bus.frag_ready_o, 0);
        chk("rst_flush_done", bus.flush_done_o, 0);
        rst = 1'b0;
        wait_done(n);
        chk("reset_sweep_len", n, DEPTH);
        chk("reset_done_pulses", done_cnt, 1);
        chk("done_one_cycle", bus.flush_done_o, 0);
        chk("idle_ready", bus.frag_ready_o, 1);

        // Basic LESS sequence at (5,7)
        send(5, 7, 100, LESS, 1, t[0], g);
        send(5, 7, 120, LESS, 1, t[1], g);
        send(5, 7, 80, LESS, 1, t[2], g);
        wait_idle();
        chk("less_first", got_pass[t[0]], 1);
        chk("less_behind", got_pass[t[1]], 0);
        chk("less_front", got_pass[t[2]], 1);

        // Back-to-back same address
        send(3, 3, 50, LESS, 1, t[0], g);
        gsum = g;
        send(3, 3, 60, LESS, 1, t[1], g2);
        gsum += g2;
        send(3, 3, 45, LESS, 1, t[2], g);
        gsum += g;
        send(3, 3, 44, LESS, 1, t[3], g);
        gsum += g;
        send(3, 3, 46, LESS, 1, t[4], g);
        gsum += g;
        wait_idle();
        chk("b2b_gap", g2, EXP_GAP);
        chk("b2b_gap_total", gsum, 4 * EXP_GAP);
        chk("b2b_p0", got_pass[t[0]], 1);
        chk("b2b_p1", got_pass[t[1]], 0);
        chk("b2b_p2", got_pass[t[2]], 1);
        chk("b2b_p3", got_pass[t[3]], 1);
        chk("b2b_p4", got_pass[t[4]], 0);

        // Mode truth table against stored 200
        send(1, 1, 200, ALWAYS, 1, t[0], g);
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 3; k++) begin
                send(1, 1, 199 + k, m, 0, tt_tag[m][k], g);
            end
        end
        send(0, 5, 10, NEVER, 1, t[1], g);
        send(2, 5, 10, LESS, 0, t[2], g);
        wait_idle();
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("mode%0d_z%0d", m, 199 + k), got_pass[tt_tag[m][k]], tt[m][2-k]);
            end
        end
        chk("never_invalid", got_pass[t[1]], 0);
        chk("less_invalid", got_pass[t[2]], 1);

        // Backpressure with three fragments in flight
        r0 = res_cnt;
        bus.res_ready_i = 1'b0;
        send(0, 6, 1, ALWAYS, 0, t[0], g);
        send(1, 6, 2, ALWAYS, 0, t[1], g);
        send(2, 6, 3, ALWAYS, 0, t[2], g);
        t[3] = tag_ctr;
        tag_ctr++;
        bus.frag_x_i = 4'(3);
        bus.frag_y_i = 3'(6);
        bus.frag_z_i = 16'(4);
        bus.cmp_mode_i = 3'(ALWAYS);
        bus.zwrite_i = 1'b0;
        bus.frag_tag_i = 8'(t[3]);
        bus.frag_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready_low", bus.frag_ready_o, 0);
            chk("bp_res_held", bus.res_valid_o, 1);
            @(posedge clk);
            #2;
        end
        bus.res_ready_i = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = bus.frag_ready_o;
            @(posedge clk);
            #2;
            n++;
        end
        bus.frag_valid_i = 1'b0;
        chk("bp_resume_accept", got, 1);
        wait_idle();
        chk("bp_result_count", res_cnt - r0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_tag_order%0d", i), tag_log[tag_log.size() - 4 + i], t[i]);
        end

        // Flush racing a fragment, with flush held into DRAIN
        send(0, 0, 10, LESS, 1, t[0], g);
        d0 = done_cnt;
        bus.flush_i = 1'b1;
        bus.frag_x_i = 4'(0);
        bus.frag_y_i = 3'(0);
        bus.frag_z_i = 16'(5);
        bus.cmp_mode_i = 3'(ALWAYS);
        bus.zwrite_i = 1'b1;
        bus.frag_tag_i = 8'(tag_ctr);
        bus.frag_valid_i = 1'b1;
        busy = 0;
        acc = 0;
        got = 1'b0;
        n = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            if (n == 0) chk("flush_wins", bus.frag_ready_o, 0);
            if (bus.frag_valid_i && bus.frag_ready_o) acc++;
            if (bus.flush_busy_o) busy++;
            got = bus.flush_done_o;
            @(posedge clk);
            #2;
            n++;
            if (n == 3) bus.flush_i = 1'b0;
            if (n == 5) bus.frag_valid_i = 1'b0;
        end
        chk("flush_done_seen", got, 1);
        chk("flush_no_accept", acc, 0);
        chk("flush_busy_len_ok", (busy >= DEPTH + 1 && busy <= DEPTH + 4) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("flush_single_done", done_cnt - d0, 1);
        send(0, 0, 900, LESS, 1, t[1], g);
        wait_idle();
        chk("pre_flush_write", got_pass[t[0]], 1);
        chk("post_flush_pass", got_pass[t[1]], 1);

        // Out-of-range x must not alias onto the next row
        send(0, 3, 300, ALWAYS, 1, t[0], g);
        send(XR, 2, 5, ALWAYS, 1, t[1], g);
        send(0, 3, 300, EQUAL, 0, t[2], g);
        wait_idle();
        chk("oor_fail", got_pass[t[1]], 0);
        chk("oor_no_alias", got_pass[t[2]], 1);

        // Reset in the middle of a sweep restarts it
        d0 = done_cnt;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #2;
        bus.flush_i = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #2;
        bus.flush_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("mid_sweep_busy", bus.flush_busy_o, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rst_busy", bus.flush_busy_o, 1);
        chk("mid_rst_ready", bus.frag_ready_o, 0);
        rst = 1'b0;
        wait_done(n);
        chk("restart_sweep_len", n, DEPTH);
        repeat (3) @(posedge clk);
        #2;
        chk("restart_single_done", done_cnt - d0, 1);
        send(5, 7, 50, GREATER, 0, t[0], g);
        wait_idle();
        chk("post_restart_invalid", got_pass[t[0]], 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
